fft_addr_gen: RTL and testbench

Control and address generator for the 256-point radix-2 DIT in-place FFT core. On `start` it sequences 8 stages × 128 butterflies. Each cycle it issues the two data-RAM read addresses and the 10-bit twiddle ROM address `{stage, bfly}` that the twiddle ROM expects. It delays the same data-RAM addresses through a fixed-latency pipeline to produce the matching write-back addresses. It drains that pipeline between stages so that no read overtakes a pending write.

---
 rtl/fft_addr_gen.sv | 142 ++++++++++++++
 tb/tb_fft_addr_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// Read/twiddle/write-back address sequencer for a 256-point radix-2 DIT in-place FFT.
// Eight stages of 128 butterflies. The pipeline is drained between stages so reads never overtake writes.
module fft_addr_gen #(
   parameter int BF_LATENCY = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [2:0] stage_o,
   output logic       rd_en_o,
   output logic [7:0] rd_addr_a_o,
   output logic [7:0] rd_addr_b_o,
   output logic [9:0] tw_addr_o,
   output logic       wr_en_o,
   output logic [7:0] wr_addr_a_o,
   output logic [7:0] wr_addr_b_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [3:0] CNT_LAST = 4'(BF_LATENCY - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] stage_q, stage_d;
   logic [6:0] bfly_q, bfly_d;
   logic [3:0] cnt_q, cnt_d;

   logic       rd_en_q, busy_q, done_q;
   logic [7:0] rd_a_q, rd_b_q;
   logic [9:0] tw_q;

   logic [BF_LATENCY-1:0]       vld_pipe_q;
   logic [BF_LATENCY-1:0][7:0]  wa_pipe_q, wb_pipe_q;

   logic       run_d;
   logic [7:0] mask_d, a_d, b_d;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      bfly_d  = bfly_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               stage_d = 3'd0;
               bfly_d  = 7'd0;
            end
         end
         S_RUN: begin
            if (bfly_q == 7'd127) begin
               state_d = S_DRAIN;
               cnt_d   = 4'd0;
            end else begin
               bfly_d = bfly_q + 7'd1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_LAST) begin
               if (stage_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  stage_d = stage_q + 3'd1;
                  bfly_d  = 7'd0;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            stage_d = 3'd0;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   // a = g*2h + j: bits above the low 'stage' bits of bfly move up one place; b sets bit 'stage'.
   always_comb begin
      run_d  = (state_d == S_RUN);
      mask_d = 8'((9'd1 << stage_d) - 9'd1);
      a_d    = 8'(({1'b0, bfly_d} & ~mask_d) << 1) | ({1'b0, bfly_d} & mask_d);
      b_d    = a_d | (8'd1 << stage_d);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         stage_q <= 3'd0;
         bfly_q  <= 7'd0;
         cnt_q   <= 4'd0;
         rd_en_q <= 1'b0;
         rd_a_q  <= 8'd0;
         rd_b_q  <= 8'd0;
         tw_q    <= 10'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         cnt_q   <= cnt_d;
         rd_en_q <= run_d;
         rd_a_q  <= run_d ? a_d : 8'd0;
         rd_b_q  <= run_d ? b_d : 8'd0;
         tw_q    <= run_d ? {stage_d, bfly_d} : 10'd0;
         busy_q  <= run_d || (state_d == S_DRAIN);
         done_q  <= (state_d == S_DONE);
      end
   end

   // Write-back delay line; shifts every cycle regardless of state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld_pipe_q <= '0;
         wa_pipe_q  <= '0;
         wb_pipe_q  <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[BF_LATENCY-2:0], rd_en_q};
         wa_pipe_q  <= {wa_pipe_q[BF_LATENCY-2:0], rd_a_q};
         wb_pipe_q  <= {wb_pipe_q[BF_LATENCY-2:0], rd_b_q};
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign stage_o     = stage_q;
   assign rd_en_o     = rd_en_q;
   assign rd_addr_a_o = rd_a_q;
   assign rd_addr_b_o = rd_b_q;
   assign tw_addr_o   = tw_q;
   assign wr_en_o     = vld_pipe_q[BF_LATENCY-1];
   assign wr_addr_a_o = wa_pipe_q[BF_LATENCY-1];
   assign wr_addr_b_o = wb_pipe_q[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: three instances (latency 2, 4, 15) share clock, reset and start.
// Each task walks a transform cycle by cycle against hand-derived timing and address rules.
module tb_fft_addr_gen;

   logic clk = 1'b0;
   logic rst_n;
   logic start;

   logic       busy_w [3];
   logic       done_w [3];
   logic [2:0] stage_w[3];
   logic       rd_w   [3];
   logic [7:0] rda_w  [3];
   logic [7:0] rdb_w  [3];
   logic [9:0] tw_w   [3];
   logic       wr_w   [3];
   logic [7:0] wra_w  [3];
   logic [7:0] wrb_w  [3];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      fft_addr_gen #(.BF_LATENCY(gi == 0 ? 2 : (gi == 1 ? 4 : 15))) u_dut (
         .clk_i      (clk),
         .rst_n_i    (rst_n),
         .start_i    (start),
         .busy_o     (busy_w[gi]),
         .done_o     (done_w[gi]),
         .stage_o    (stage_w[gi]),
         .rd_en_o    (rd_w[gi]),
         .rd_addr_a_o(rda_w[gi]),
         .rd_addr_b_o(rdb_w[gi]),
         .tw_addr_o  (tw_w[gi]),
         .wr_en_o    (wr_w[gi]),
         .wr_addr_a_o(wra_w[gi]),
         .wr_addr_b_o(wrb_w[gi])
      );
   end

   function automatic int lat(input int idx);
      return (idx == 0) ? 2 : ((idx == 1) ? 4 : 15);
   endfunction

   task automatic test_reset();
      logic [53:0] got;
      start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         got = {busy_w[i], done_w[i], stage_w[i], rd_w[i], rda_w[i], rdb_w[i], tw_w[i],
                wr_w[i], wra_w[i], wrb_w[i]};
         vectors++;
         if (got !== 54'd0) begin
            miscompares++;
            $display("FAIL reset_outputs inst=%0d got=%h want=0", i, got);
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({busy_w[i], rd_w[i], wr_w[i], done_w[i]} !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset inst=%0d got=%b want=0000", i,
                     {busy_w[i], rd_w[i], wr_w[i], done_w[i]});
         end
      end
   endtask

   // Start pulse in cycle 0; checks cycles 1..ncyc of instance idx.
   // ign0/ign1: extra start pulses that must be ignored. hold: start stays high.
   task automatic test_run(input int idx, input int ign0, input int ign1, input bit hold,
                           input int ncyc, input bit totals);
      int L, P, T, te, s, k, h, ea, eb, etw, ws, wk, wh, wa, wb;
      bit erd, ewr;
      int n_rd, n_wr, n_done;
      logic [255:0] seen;
      int dups;
      L = lat(idx); P = 128 + L; T = 8 * P;
      n_rd = 0; n_wr = 0; n_done = 0; seen = '0; dups = 0;
      @(negedge clk);
      start = 1'b1;
      for (int t = 1; t <= ncyc; t++) begin
         @(negedge clk);
         start = hold ? 1'b1 : ((t == ign0) || (t == ign1));
         te = hold ? (t % (T + 2)) : t;
         erd = (te >= 1) && (te <= T) && (((te - 1) % P) < 128);
         s = erd ? (te - 1) / P : 0;
         k = erd ? (te - 1) % P : 0;
         h = 1 << s;
         ea = erd ? (k / h) * 2 * h + (k % h) : 0;
         eb = erd ? ea + h : 0;
         etw = erd ? s * 128 + k : 0;
         ewr = (te - L >= 1) && (te - L <= T) && (((te - L - 1) % P) < 128);
         ws = ewr ? (te - L - 1) / P : 0;
         wk = ewr ? (te - L - 1) % P : 0;
         wh = 1 << ws;
         wa = ewr ? (wk / wh) * 2 * wh + (wk % wh) : 0;
         wb = ewr ? wa + wh : 0;

         vectors++;
         if ({rd_w[idx], rda_w[idx], rdb_w[idx], tw_w[idx]} !== {erd, 8'(ea), 8'(eb), 10'(etw)}) begin
            miscompares++;
            $display("FAIL rd_port L=%0d t=%0d got en=%b a=%0d b=%0d tw=%0d want en=%b a=%0d b=%0d tw=%0d",
                     L, t, rd_w[idx], rda_w[idx], rdb_w[idx], tw_w[idx], erd, ea, eb, etw);
         end
         vectors++;
         if ({wr_w[idx], wra_w[idx], wrb_w[idx]} !== {ewr, 8'(wa), 8'(wb)}) begin
            miscompares++;
            $display("FAIL wr_port L=%0d t=%0d got en=%b a=%0d b=%0d want en=%b a=%0d b=%0d",
                     L, t, wr_w[idx], wra_w[idx], wrb_w[idx], ewr, wa, wb);
         end
         vectors++;
         if ({busy_w[idx], done_w[idx]} !== {(te >= 1) && (te <= T), te == T + 1}) begin
            miscompares++;
            $display("FAIL busy_done L=%0d t=%0d got=%b%b want=%b%b", L, t, busy_w[idx], done_w[idx],
                     (te >= 1) && (te <= T), te == T + 1);
         end
         if ((te >= 1) && (te <= T)) begin
            vectors++;
            if (stage_w[idx] !== 3'((te - 1) / P)) begin
               miscompares++;
               $display("FAIL stage L=%0d t=%0d got=%0d want=%0d", L, t, stage_w[idx], (te - 1) / P);
            end
         end
         if (erd && s == 3 && k == 13) begin
            vectors++;
            if ({rda_w[idx], rdb_w[idx], tw_w[idx]} !== {8'd21, 8'd29, 10'd397}) begin
               miscompares++;
               $display("FAIL s3_b13 got %0d/%0d/%0d want 21/29/397", rda_w[idx], rdb_w[idx], tw_w[idx]);
            end
         end
         if (erd && s == 7 && k == 127) begin
            vectors++;
            if ({rda_w[idx], rdb_w[idx], tw_w[idx]} !== {8'd127, 8'd255, 10'd1023}) begin
               miscompares++;
               $display("FAIL s7_b127 got %0d/%0d/%0d want 127/255/1023", rda_w[idx], rdb_w[idx], tw_w[idx]);
            end
         end
         if (t <= T + 1) begin
            if (rd_w[idx] === 1'b1) begin
               n_rd++;
               if (seen[rda_w[idx]] || seen[rdb_w[idx]]) dups++;
               seen[rda_w[idx]] = 1'b1;
               seen[rdb_w[idx]] = 1'b1;
            end
            if (wr_w[idx] === 1'b1) n_wr++;
            if (done_w[idx] === 1'b1) n_done++;
            if (erd && k == 127) begin
               vectors++;
               if (seen !== {256{1'b1}} || dups != 0) begin
                  miscompares++;
                  $display("FAIL stage_coverage L=%0d stage=%0d dups=%0d want full cover dups=0", L, s, dups);
               end
               seen = '0;
               dups = 0;
            end
         end
      end
      start = 1'b0;
      if (totals) begin
         vectors++;
         if (n_rd != 1024 || n_wr != 1024 || n_done != 1) begin
            miscompares++;
            $display("FAIL totals L=%0d got rd=%0d wr=%0d done=%0d want 1024/1024/1", L, n_rd, n_wr, n_done);
         end
      end
   endtask

   task automatic test_latency_sweep();
      test_run(0, -1, -1, 1'b0, 1150, 1'b1);
      test_run(2, -1, -1, 1'b0, 1150, 1'b1);
   endtask

   task automatic test_start_ignored();
      test_run(1, 50, 130, 1'b0, 1150, 1'b1);
   endtask

   task automatic test_reset_mid();
      test_run(1, -1, -1, 1'b0, 599, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({busy_w[i], done_w[i], stage_w[i], rd_w[i], rda_w[i], rdb_w[i], tw_w[i],
              wr_w[i], wra_w[i], wrb_w[i]} !== 54'd0) begin
            miscompares++;
            $display("FAIL async_reset inst=%0d outputs not zero", i);
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         vectors++;
         if ({wr_w[1], rd_w[1], busy_w[1]} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_quiet c=%0d got wr/rd/busy=%b want 000", c, {wr_w[1], rd_w[1], busy_w[1]});
         end
      end
      test_run(1, -1, -1, 1'b0, 1150, 1'b1);
   endtask

   task automatic test_back_to_back();
      // Second transform's first read lands at t = 1059, two cycles after the first done at 1057.
      test_run(1, -1, -1, 1'b1, 1058 + 140, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      test_reset();
      test_start_ignored();
      test_latency_sweep();
      test_reset_mid();
      test_back_to_back();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
